// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    RELEASE,
    RUN
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian word assembler: the first byte of a word lands in bits [31:24],
// and the fourth byte completes the word combinationally with a one-cycle word_valid.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] idx_reg;
  logic [7:0] lane_reg [0:BYTES_PER_WORD-2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg <= '0;
    end else if (byte_valid) begin
      idx_reg <= idx_reg + 2'd1;
    end
  end

  // Each of the first three bytes parks in its own lane; the fourth passes straight through.
  for (genvar gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lane_reg[gi] <= '0;
      end else if (byte_valid && idx_reg == 2'(gi)) begin
        lane_reg[gi] <= byte_data;
      end
    end
  end

  assign word_valid = byte_valid && (idx_reg == 2'(BYTES_PER_WORD - 1));
  assign word       = {lane_reg[0], lane_reg[1], lane_reg[2], byte_data};

endmodule

// File: rtl/imem_loader.sv
// Streams a counted, big-endian word image into instruction memory, then releases
// the CPU from reset after a fixed settle period and latches its overflow flag.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              load_err,
  input  logic              ovf,
  output logic              ovf_sticky
);

  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  state_t              state_reg, state_next;
  logic [COUNT_W-1:0]  count_reg;
  logic [COUNT_W-1:0]  word_idx_reg;
  logic [REL_W-1:0]    rel_cnt_reg;
  logic                imem_we_reg;
  logic [ADDR_W-1:0]   imem_addr_reg;
  logic [31:0]         imem_wdata_reg;
  logic                cpu_reset_reg, cpu_reset_next;
  logic                done_reg, done_next;
  logic                load_err_reg;
  logic                ovf_sticky_reg;

  logic                ready_comb;
  logic                accept;
  logic                word_valid;
  logic [31:0]         word;
  logic                in_range;
  logic                last_word;

  assign accept    = in_valid && ready_comb;
  assign in_range  = (word_idx_reg >> ADDR_W) == '0;
  assign last_word = (word_idx_reg == count_reg - COUNT_W'(1));

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (accept && (state_reg == DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= HDR_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HDR_HI:  if (accept) state_next = HDR_LO;
      HDR_LO:  if (accept) state_next = ({count_reg[15:8], in_data} == '0) ? RELEASE : DATA;
      DATA:    if (word_valid && last_word) state_next = RELEASE;
      RELEASE: if (rel_cnt_reg == '0) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = HDR_HI;
    endcase
  end

  always_comb begin
    ready_comb     = (state_reg == HDR_HI) || (state_reg == HDR_LO) || (state_reg == DATA);
    cpu_reset_next = (state_next != RUN);
    done_next      = (state_next == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg      <= '0;
      word_idx_reg   <= '0;
      rel_cnt_reg    <= REL_W'(RELEASE_CYCLES - 1);
      imem_we_reg    <= 1'b0;
      imem_addr_reg  <= '0;
      imem_wdata_reg <= '0;
      cpu_reset_reg  <= 1'b1;
      done_reg       <= 1'b0;
      load_err_reg   <= 1'b0;
      ovf_sticky_reg <= 1'b0;
    end else begin
      if (accept && state_reg == HDR_HI) count_reg[15:8] <= in_data;
      if (accept && state_reg == HDR_LO) count_reg[7:0]  <= in_data;

      // Counter is preloaded outside RELEASE so the settle period starts on entry.
      if (state_reg != RELEASE) begin
        rel_cnt_reg <= REL_W'(RELEASE_CYCLES - 1);
      end else if (rel_cnt_reg != '0) begin
        rel_cnt_reg <= rel_cnt_reg - REL_W'(1);
      end

      imem_we_reg <= word_valid && in_range;
      if (word_valid && in_range) begin
        imem_addr_reg  <= word_idx_reg[ADDR_W-1:0];
        imem_wdata_reg <= word;
      end
      if (word_valid) begin
        word_idx_reg <= word_idx_reg + COUNT_W'(1);
        if (!in_range) load_err_reg <= 1'b1;
      end

      if (state_reg == RUN && ovf) ovf_sticky_reg <= 1'b1;

      cpu_reset_reg <= cpu_reset_next;
      done_reg      <= done_next;
    end
  end

  assign in_ready   = ready_comb;
  assign imem_we    = imem_we_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = imem_wdata_reg;
  assign cpu_reset  = cpu_reset_reg;
  assign done       = done_reg;
  assign load_err   = load_err_reg;
  assign ovf_sticky = ovf_sticky_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: two loaders (deep memory / 4-word memory) share one byte stream;
// expected writes are queued per word and a negedge monitor compares each strobe.
module tb_imem_loader;

  localparam int RA = 4;
  localparam int RB = 1;
  localparam int DEPTH_A = 256;
  localparam int DEPTH_B = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, ovf;
  logic [7:0]  in_data;

  logic        a_in_ready, a_we, a_cpu_reset, a_done, a_load_err, a_ovf_sticky;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_in_ready, b_we, b_cpu_reset, b_done, b_load_err, b_ovf_sticky;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  wr_t         ea, eb;
  logic [31:0] words[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  imem_loader #(.ADDR_W(8), .RELEASE_CYCLES(RA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .cpu_reset(a_cpu_reset),
    .done(a_done), .load_err(a_load_err), .ovf(ovf), .ovf_sticky(a_ovf_sticky)
  );

  imem_loader #(.ADDR_W(2), .RELEASE_CYCLES(RB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .cpu_reset(b_cpu_reset),
    .done(b_done), .load_err(b_load_err), .ovf(ovf), .ovf_sticky(b_ovf_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitors: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_write", a_we, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_wr_addr", a_addr, ea.addr);
        chk("a_wr_data", a_wdata, ea.data);
        chk("a_wr_cycle", cyc, ea.cyc);
        $display("dut_a write addr=%0d data=%h cycle=%0d", a_addr, a_wdata, cyc);
      end
    end
    if (b_we === 1'b1) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_write", b_we, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_wr_addr", b_addr, eb.addr);
        chk("b_wr_data", b_wdata, eb.data);
        chk("b_wr_cycle", cyc, eb.cyc);
        $display("dut_b write addr=%0d data=%h cycle=%0d", b_addr, b_wdata, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick_gap(input int mode);
    return (mode == 1) || (mode == 2 && $urandom_range(0, 2) == 0);
  endfunction

  task automatic do_reset();
    tick();
    reset = 1'b1; in_valid = 1'b0; ovf = 1'b0;
    #1;
    chk("a_rst_in_ready", a_in_ready, 1);     chk("b_rst_in_ready", b_in_ready, 1);
    chk("a_rst_we", a_we, 0);                 chk("b_rst_we", b_we, 0);
    chk("a_rst_addr", a_addr, 0);             chk("a_rst_wdata", a_wdata, 0);
    chk("a_rst_cpu_reset", a_cpu_reset, 1);   chk("b_rst_cpu_reset", b_cpu_reset, 1);
    chk("a_rst_done", a_done, 0);             chk("a_rst_load_err", a_load_err, 0);
    chk("a_rst_ovf_sticky", a_ovf_sticky, 0); chk("b_rst_load_err", b_load_err, 0);
    chk("a_pending_writes", qa.size(), 0);    chk("b_pending_writes", qb.size(), 0);
    tick();
    reset = 1'b0;
    ovf = 1'b1;   // overflow while still loading must be ignored
    tick();
    ovf = 1'b0;
    chk("a_ovf_in_load", a_ovf_sticky, 0);    chk("b_ovf_in_load", b_ovf_sticky, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap, output int unsigned c);
    if (gap) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    c = cyc;
    chk("a_in_ready", a_in_ready, 1);
    chk("b_in_ready", b_in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // n words from 'words'; limit >= 0 stops after that many data bytes (abort case).
  task automatic load(input int n, input int gapmode, input int limit, input bit pulse);
    logic [15:0] cnt;
    logic [31:0] w;
    int unsigned c, fa, fb;
    int sent;
    cnt = 16'(n);
    sent = 0;
    do_reset();
    $display("load: count=%0d gapmode=%0d limit=%0d", n, gapmode, limit);
    send_byte(cnt[15:8], pick_gap(gapmode), c);
    send_byte(cnt[7:0], pick_gap(gapmode), c);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (limit >= 0 && sent == limit) begin
          ovf = 1'b0;
          return;
        end
        ovf = 1'($urandom_range(0, 1));
        send_byte(8'(w >> (8 * (3 - k))), pick_gap(gapmode), c);
        sent++;
        if (k == 3) begin
          if (i < DEPTH_A) qa.push_back('{addr: i, data: w, cyc: c + 1});
          if (i < DEPTH_B) qb.push_back('{addr: i, data: w, cyc: c + 1});
        end
      end
    end
    ovf = 1'b0;
    fa = 0;
    fb = 0;
    tick();
    chk("a_in_ready_release", a_in_ready, 0);
    chk("b_in_ready_release", b_in_ready, 0);
    for (int k = 0; k < 40; k++) begin
      if (fa == 0 && a_cpu_reset == 1'b0) fa = cyc;
      if (fb == 0 && b_cpu_reset == 1'b0) fb = cyc;
      if (fa != 0 && fb != 0) break;
      tick();
    end
    chk("a_release_latency", fa, c + 1 + RA);
    chk("b_release_latency", fb, c + 1 + RB);
    chk("a_done", a_done, 1);                 chk("b_done", b_done, 1);
    chk("a_load_err", a_load_err, n > DEPTH_A);
    chk("b_load_err", b_load_err, n > DEPTH_B);
    chk("a_missing_writes", qa.size(), 0);    chk("b_missing_writes", qb.size(), 0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("a_ovf_clear", a_ovf_sticky, 0);      chk("b_ovf_clear", b_ovf_sticky, 0);
    if (pulse) begin
      ovf = 1'b1;
      tick();
      ovf = 1'b0;
      chk("a_ovf_set", a_ovf_sticky, 1);      chk("b_ovf_set", b_ovf_sticky, 1);
      tick();
      tick();
      chk("a_ovf_hold", a_ovf_sticky, 1);     chk("b_ovf_hold", b_ovf_sticky, 1);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; ovf = 1'b0;

    words = {32'h12345678, 32'h9ABCDEF0};
    load(2, 0, -1, 1'b1);

    words.delete();
    load(0, 0, -1, 1'b0);

    words = {32'h12345678, 32'h9ABCDEF0};
    load(2, 1, -1, 1'b0);

    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    load(5, 0, -1, 1'b1);

    words = {32'h0BADF00D, 32'hCAFEBABE};
    load(2, 0, 6, 1'b0);
    chk("a_cpu_reset_abort", a_cpu_reset, 1);
    chk("b_cpu_reset_abort", b_cpu_reset, 1);
    words = {32'hAABBCCDD};
    load(1, 0, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(0, 7);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      load(n, 2, -1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
